spi_pwm_cfg_ctrl: RTL and testbench

SPI-slave configuration controller that owns the PWM peripheral's register bank. It synchronises the raw SCLK/nCS/COPI pins into the system clock domain, deserialises 16-bit write frames and commits them atomically into the five PWM control registers. Its outputs drive the PWM peripheral's enable and duty-cycle inputs directly, and it sits between the dedicated input pins and that peripheral.

---
 rtl/spi_pwm_cfg_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_spi_pwm_cfg_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_cfg_ctrl.sv
// spi_pwm_cfg_ctrl
// SPI-slave (mode 0, write-only) configuration controller for the PWM
// peripheral. It synchronises the raw SPI pins into the clk domain, collects
// 16-bit frames (bit15 = R/W, bits14:8 = address, bits7:0 = data, MSB first)
// and commits valid writes atomically into a five-register bank.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   sclk, ncs, copi   raw SPI pins, asynchronous to clk
//   en_reg_out_7_0    reg 0x00, output enables out[7:0]
//   en_reg_out_15_8   reg 0x01, output enables out[15:8]
//   en_reg_pwm_7_0    reg 0x02, PWM mode enables out[7:0]
//   en_reg_pwm_15_8   reg 0x03, PWM mode enables out[15:8]
//   pwm_duty_cycle    reg 0x04, shared duty cycle
//   cfg_update        one-cycle pulse when a register is written
//   frame_err         one-cycle pulse when a write frame is discarded
module spi_pwm_cfg_ctrl #(
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_update,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [4:0] LP_FULL_COUNT = 5'd16;
  localparam logic [4:0] LP_SAT_COUNT  = 5'd17;
  localparam logic [7:0] LP_NUM_REGS   = 8'(NUM_REGS);

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_ncsSync;
  logic [SYNC_STAGES-1:0] r_copiSync;
  logic                   r_sclkHist;
  logic                   r_ncsHist;
  logic                   r_copiHist;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_shiftReg;
  logic [4:0]  r_bitCount;
  logic        r_startPending;
  logic [7:0]  r_reg0;
  logic [7:0]  r_reg1;
  logic [7:0]  r_reg2;
  logic [7:0]  r_reg3;
  logic [7:0]  r_reg4;
  logic        r_cfgUpdate;
  logic        r_frameErr;

  logic       w_sclkRise;
  logic       w_ncsRise;
  logic       w_ncsFall;
  logic       w_clearFrame;
  logic       w_shiftBit;
  logic       w_commit;
  logic [6:0] w_addr;
  logic       w_isRead;
  logic       w_valid;
  logic       w_err;

  // Synchroniser chains reset to 0 so that ncs held low through reset never
  // looks like a falling edge; a frame only starts after ncs rises and falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclkSync <= '0;
      r_ncsSync  <= '0;
      r_copiSync <= '0;
      r_sclkHist <= 1'b0;
      r_ncsHist  <= 1'b0;
      r_copiHist <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
      r_ncsSync  <= {r_ncsSync[SYNC_STAGES-2:0], ncs};
      r_copiSync <= {r_copiSync[SYNC_STAGES-2:0], copi};
      r_sclkHist <= r_sclkSync[SYNC_STAGES-1];
      r_ncsHist  <= r_ncsSync[SYNC_STAGES-1];
      r_copiHist <= r_copiSync[SYNC_STAGES-1];
    end
  end

  assign w_sclkRise = r_sclkSync[SYNC_STAGES-1] & ~r_sclkHist;
  assign w_ncsRise  = r_ncsSync[SYNC_STAGES-1] & ~r_ncsHist;
  assign w_ncsFall  = ~r_ncsSync[SYNC_STAGES-1] & r_ncsHist;

  assign w_addr   = r_shiftReg[14:8];
  assign w_isRead = (r_bitCount == LP_FULL_COUNT) && !r_shiftReg[15];
  assign w_valid  = (r_bitCount == LP_FULL_COUNT) && r_shiftReg[15] &&
                    ({1'b0, w_addr} < LP_NUM_REGS);
  // Read frames are dropped silently; anything else that is not a valid
  // write (wrong length or bad address) is reported.
  assign w_err    = !w_valid && !w_isRead;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state and datapath strobes.
  always_comb begin
    w_nextState  = r_state;
    w_clearFrame = 1'b0;
    w_shiftBit   = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ncsFall || r_startPending) begin
          w_clearFrame = 1'b1;
          w_nextState  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shiftBit = w_sclkRise;
        if (w_ncsRise) begin
          w_nextState = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Frame deserialiser. The counter stops at 17 so any overlong frame stays
  // distinguishable from a 16-bit one. A chip-select fall seen during COMMIT
  // is remembered so IDLE can start the next frame without missing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shiftReg     <= '0;
      r_bitCount     <= '0;
      r_startPending <= 1'b0;
    end else begin
      if (w_clearFrame) begin
        r_shiftReg <= '0;
        r_bitCount <= '0;
      end else if (w_shiftBit) begin
        r_shiftReg <= {r_shiftReg[14:0], r_copiHist};
        if (r_bitCount != LP_SAT_COUNT) begin
          r_bitCount <= r_bitCount + 5'd1;
        end
      end
      if ((r_state == ST_COMMIT) && w_ncsFall) begin
        r_startPending <= 1'b1;
      end else if (r_state == ST_IDLE) begin
        r_startPending <= 1'b0;
      end
    end
  end

  // Register bank and status pulses; only the COMMIT cycle can change them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg0      <= '0;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_reg3      <= '0;
      r_reg4      <= '0;
      r_cfgUpdate <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_cfgUpdate <= w_commit && w_valid;
      r_frameErr  <= w_commit && w_err;
      if (w_commit && w_valid) begin
        case (w_addr)
          7'd0:    r_reg0 <= r_shiftReg[7:0];
          7'd1:    r_reg1 <= r_shiftReg[7:0];
          7'd2:    r_reg2 <= r_shiftReg[7:0];
          7'd3:    r_reg3 <= r_shiftReg[7:0];
          7'd4:    r_reg4 <= r_shiftReg[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_reg0;
  assign en_reg_out_15_8 = r_reg1;
  assign en_reg_pwm_7_0  = r_reg2;
  assign en_reg_pwm_15_8 = r_reg3;
  assign pwm_duty_cycle  = r_reg4;
  assign cfg_update      = r_cfgUpdate;
  assign frame_err       = r_frameErr;

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// tb_spi_pwm_cfg_ctrl
// Directed testbench for spi_pwm_cfg_ctrl. A frame-level model tracks what
// the register bank and the status pulses must be; a per-cycle compare
// process checks the DUT against it, and literal checks after each scenario
// pin the model to hand-computed values.
module tb_spi_pwm_cfg_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       ncs   = 1'b1;
  logic       copi  = 1'b0;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       cfg_update;
  logic       frame_err;

  spi_pwm_cfg_ctrl #(
    .NUM_REGS   (5),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .ncs            (ncs),
    .copi           (copi),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .cfg_update     (cfg_update),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [7:0]  expReg [5];
  logic        expCfg;
  logic        expErr;
  bit          pendValid = 0;
  bit          pendWrite = 0;
  int          pendCyc   = 0;
  int          pendAddr  = 0;
  logic [7:0]  pendData  = '0;
  bit          frameOpen = 0;
  int          bitCnt    = 0;
  logic [31:0] frameBits = '0;

  int checks  = 0;
  int fails   = 0;
  int cfgSeen = 0;
  int errSeen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare: applies a scheduled commit on the cycle the outputs
  // must reflect it, then checks every output.
  always @(negedge clk) begin
    expCfg = 1'b0;
    expErr = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) expReg[i] = 8'h00;
      pendValid = 0;
    end else if (pendValid && (cyc == pendCyc)) begin
      pendValid = 0;
      if (pendWrite) begin
        expReg[pendAddr] = pendData;
        expCfg = 1'b1;
      end else begin
        expErr = 1'b1;
      end
    end
    checkOutput("en_reg_out_7_0",  en_reg_out_7_0,  expReg[0]);
    checkOutput("en_reg_out_15_8", en_reg_out_15_8, expReg[1]);
    checkOutput("en_reg_pwm_7_0",  en_reg_pwm_7_0,  expReg[2]);
    checkOutput("en_reg_pwm_15_8", en_reg_pwm_15_8, expReg[3]);
    checkOutput("pwm_duty_cycle",  pwm_duty_cycle,  expReg[4]);
    checkOutput("cfg_update",      cfg_update,      expCfg);
    checkOutput("frame_err",       frame_err,       expErr);
    if (cfg_update === 1'b1) cfgSeen++;
    if (frame_err === 1'b1) errSeen++;
  end

  // Leaves the caller 1 time unit after a rising clk edge.
  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives chip select and, on its rising edge, decides the frame outcome:
  // a 16-bit write to address 0..4 commits, a 16-bit read is ignored, and
  // everything else is an error. Outputs reflect it 4 clk edges later.
  task automatic setNcs(input logic v);
    logic [15:0] f;
    ncs = v;
    if (!v && rst_n) begin
      frameOpen = 1;
      bitCnt    = 0;
      frameBits = '0;
    end else if (v && frameOpen) begin
      frameOpen = 0;
      f = frameBits[15:0];
      if (!((bitCnt == 16) && !f[15])) begin
        pendValid = 1;
        pendCyc   = cyc + 4;
        if ((bitCnt == 16) && (f[14:8] < 7'd5)) begin
          pendWrite = 1;
          pendAddr  = int'(f[14:8]);
          pendData  = f[7:0];
        end else begin
          pendWrite = 0;
        end
      end
    end
  endtask

  // One SPI bit: 4 clk low with data set up, 4 clk high.
  task automatic sclkBit(input logic b);
    copi = b;
    waitClk(4);
    sclk = 1'b1;
    if (!ncs && frameOpen) begin
      frameBits = {frameBits[30:0], b};
      bitCnt++;
    end
    waitClk(4);
    sclk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] bits, input int n, input int gap);
    setNcs(1'b0);
    waitClk(4);
    for (int i = n - 1; i >= 0; i--) sclkBit(bits[i]);
    waitClk(4);
    setNcs(1'b1);
    waitClk(gap);
  endtask

  logic [15:0] writeFrames [5] = '{16'h80F0, 16'h810F, 16'h82AA, 16'h8355, 16'h84C3};
  int c0, e0;

  initial begin
    for (int i = 0; i < 5; i++) expReg[i] = 8'h00;
    rst_n = 1'b0;
    ncs   = 1'b1;
    waitClk(3);
    rst_n = 1'b1;
    waitClk(3);
    checkOutput("reset_duty", pwm_duty_cycle, 32'h00);
    checkOutput("reset_pulses", cfgSeen + errSeen, 32'd0);

    $display("[TB] writing all five registers");
    c0 = cfgSeen; e0 = errSeen;
    for (int i = 0; i < 5; i++) applyStimulus({16'h0, writeFrames[i]}, 16, 10);
    checkOutput("wr_out_lo",  en_reg_out_7_0,  32'hF0);
    checkOutput("wr_out_hi",  en_reg_out_15_8, 32'h0F);
    checkOutput("wr_pwm_lo",  en_reg_pwm_7_0,  32'hAA);
    checkOutput("wr_pwm_hi",  en_reg_pwm_15_8, 32'h55);
    checkOutput("wr_duty",    pwm_duty_cycle,  32'hC3);
    checkOutput("wr_cfg_cnt", cfgSeen - c0,    32'd5);
    checkOutput("wr_err_cnt", errSeen - e0,    32'd0);

    $display("[TB] malformed frames");
    c0 = cfgSeen; e0 = errSeen;
    applyStimulus(32'h0000_4155, 15, 10);
    applyStimulus(32'h0001_8155, 17, 10);
    applyStimulus(32'h0000_8512, 16, 10);
    checkOutput("bad_err_cnt", errSeen - e0,    32'd3);
    checkOutput("bad_cfg_cnt", cfgSeen - c0,    32'd0);
    checkOutput("bad_out_hi",  en_reg_out_15_8, 32'h0F);
    checkOutput("bad_duty",    pwm_duty_cycle,  32'hC3);

    $display("[TB] read frame");
    c0 = cfgSeen; e0 = errSeen;
    applyStimulus(32'h0000_0433, 16, 10);
    checkOutput("rd_duty",    pwm_duty_cycle, 32'hC3);
    checkOutput("rd_pulses",  (cfgSeen - c0) + (errSeen - e0), 32'd0);

    $display("[TB] sclk activity with ncs high");
    c0 = cfgSeen; e0 = errSeen;
    for (int i = 0; i < 8; i++) sclkBit(i[0]);
    waitClk(4);
    applyStimulus(32'h0000_8001, 16, 10);
    checkOutput("idle_out_lo", en_reg_out_7_0,  32'h01);
    checkOutput("idle_out_hi", en_reg_out_15_8, 32'h0F);
    checkOutput("idle_pwm_lo", en_reg_pwm_7_0,  32'hAA);
    checkOutput("idle_pwm_hi", en_reg_pwm_15_8, 32'h55);
    checkOutput("idle_duty",   pwm_duty_cycle,  32'hC3);
    checkOutput("idle_cfg",    cfgSeen - c0,    32'd1);
    checkOutput("idle_err",    errSeen - e0,    32'd0);

    $display("[TB] back-to-back frames at minimum spacing");
    c0 = cfgSeen; e0 = errSeen;
    applyStimulus(32'h0000_8410, 16, 3);
    applyStimulus(32'h0000_8420, 16, 10);
    checkOutput("b2b_duty", pwm_duty_cycle, 32'h20);
    checkOutput("b2b_cfg",  cfgSeen - c0,   32'd2);
    checkOutput("b2b_err",  errSeen - e0,   32'd0);

    $display("[TB] reset in the middle of a frame");
    c0 = cfgSeen; e0 = errSeen;
    setNcs(1'b0);
    waitClk(4);
    for (int i = 15; i >= 11; i--) sclkBit(i[0] ^ i[1]);
    rst_n     = 1'b0;
    frameOpen = 0;
    waitClk(2);
    checkOutput("rst_out_lo", en_reg_out_7_0, 32'h00);
    checkOutput("rst_duty",   pwm_duty_cycle, 32'h00);
    rst_n = 1'b1;
    waitClk(3);
    for (int i = 10; i >= 0; i--) sclkBit(i[0]);
    waitClk(4);
    setNcs(1'b1);
    waitClk(10);
    checkOutput("rst_pwm_hi", en_reg_pwm_15_8, 32'h00);
    checkOutput("rst_pulses", (cfgSeen - c0) + (errSeen - e0), 32'd0);
    applyStimulus(32'h0000_8455, 16, 10);
    checkOutput("post_rst_duty",   pwm_duty_cycle, 32'h55);
    checkOutput("post_rst_out_lo", en_reg_out_7_0, 32'h00);
    checkOutput("post_rst_cfg",    cfgSeen - c0,   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
